// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default address width and Gray/binary helpers,
// used by both the write-side and read-side pointer logic.
package fifo_pkg;

    localparam int FIFO_ADDR_SIZE = 3;
    localparam int FIFO_PTR_MAX_W = 32;

    function automatic logic [FIFO_PTR_MAX_W-1:0] bin2gray(input logic [FIFO_PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended inputs are safe: leading zeros contribute nothing to the prefix XOR.
    function automatic logic [FIFO_PTR_MAX_W-1:0] gray2bin(input logic [FIFO_PTR_MAX_W-1:0] g);
        logic [FIFO_PTR_MAX_W-1:0] b;
        b[FIFO_PTR_MAX_W-1] = g[FIFO_PTR_MAX_W-1];
        for (int i = FIFO_PTR_MAX_W-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter of configurable width.
module fifo_gray2bin
    import fifo_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    assign bin_o = W'(gray2bin(FIFO_PTR_MAX_W'(gray_i)));

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: Gray write pointer, full/level/overflow flags.
// Optional almost-full flag is built only when FIFO_WR_AFULL_EN is defined.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE    = FIFO_ADDR_SIZE,
    parameter int AFULL_THRESH = 6
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 winc,
    input  logic [ADDR_SIZE:0]   wq2_rptr,
    input  logic                 wovf_clr,
    output logic [ADDR_SIZE:0]   wptr,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic                 wen,
    output logic                 wfull,
    output logic                 wafull,
    output logic [ADDR_SIZE:0]   wlevel,
    output logic                 wovf
);

    localparam int P = ADDR_SIZE + 1;
    // Full when the write pointer matches the read pointer with its two MSBs inverted.
    localparam logic [ADDR_SIZE:0] FULL_MASK = P'(3) << (ADDR_SIZE - 1);

    if (ADDR_SIZE < 1 || ADDR_SIZE > FIFO_PTR_MAX_W - 1) begin : g_bad_addr
        $error("fifo_wr_ctrl: ADDR_SIZE out of range");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > (1 << ADDR_SIZE)) begin : g_bad_thresh
        $error("fifo_wr_ctrl: AFULL_THRESH out of range");
    end

    logic [ADDR_SIZE:0] wbin_q, wbin_d;
    logic [ADDR_SIZE:0] wptr_q, wptr_d;
    logic [ADDR_SIZE:0] wlevel_q, wlevel_d;
    logic               wfull_q, wfull_d;
    logic               wovf_q, wovf_d;
    logic [ADDR_SIZE:0] rbin;
    logic               wen_c;

    fifo_gray2bin #(.W(P)) u_rptr_g2b (
        .gray_i (wq2_rptr),
        .bin_o  (rbin)
    );

    always_comb begin
        wen_c    = winc & ~wfull_q & ~wrst;
        wbin_d   = wbin_q + P'(wen_c);
        wptr_d   = P'(bin2gray(FIFO_PTR_MAX_W'(wbin_d)));
        wfull_d  = (wptr_d == (wq2_rptr ^ FULL_MASK));
        wlevel_d = wbin_d - rbin;
        wovf_d   = wovf_q;
        // A refused write sets the flag even when a clear arrives in the same cycle.
        if (winc && wfull_q) begin
            wovf_d = 1'b1;
        end else if (wovf_clr) begin
            wovf_d = 1'b0;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wovf_q   <= wovf_d;
        end
    end

`ifdef FIFO_WR_AFULL_EN
    logic wafull_q;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wafull_q <= 1'b0;
        end else begin
            wafull_q <= (wlevel_d >= P'(AFULL_THRESH));
        end
    end

    assign wafull = wafull_q;
`else
    assign wafull = 1'b0;
`endif

    assign wptr   = wptr_q;
    assign waddr  = wbin_q[ADDR_SIZE-1:0];
    assign wen    = wen_c;
    assign wfull  = wfull_q;
    assign wlevel = wlevel_q;
    assign wovf   = wovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl (ADDR_SIZE=3, AFULL_THRESH=6) with directed vectors.
module tb_fifo_wr_ctrl;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       winc = 1'b1;
    logic       wovf_clr = 1'b0;
    logic [3:0] wq2_rptr = 4'h0;
    logic [3:0] wptr;
    logic [2:0] waddr;
    logic       wen;
    logic       wfull;
    logic       wafull;
    logic [3:0] wlevel;
    logic       wovf;

    always #5 wclk = ~wclk;

`ifdef FIFO_WR_AFULL_EN
    localparam bit AF_ON = 1'b1;
`else
    localparam bit AF_ON = 1'b0;
`endif

    fifo_wr_ctrl #(.ADDR_SIZE(3), .AFULL_THRESH(6)) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .winc     (winc),
        .wq2_rptr (wq2_rptr),
        .wovf_clr (wovf_clr),
        .wptr     (wptr),
        .waddr    (waddr),
        .wen      (wen),
        .wfull    (wfull),
        .wafull   (wafull),
        .wlevel   (wlevel),
        .wovf     (wovf)
    );

    typedef struct packed {
        logic       wen;
        logic [2:0] waddr;
        logic [3:0] wptr;
        logic       full;
        logic       afull;
        logic [3:0] level;
        logic       ovf;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
    } chk_t;

    localparam logic [3:0] GRAY [0:15] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                           4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    chk_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Drive one cycle of inputs just after the edge; queue what the outputs must show this cycle.
    task automatic step(input string nm, input logic r, input logic i, input logic c,
                        input logic [3:0] rp, input bit chk,
                        input logic e_wen, input logic [2:0] e_addr, input logic [3:0] e_ptr,
                        input logic e_full, input logic e_af, input logic [3:0] e_lvl,
                        input logic e_ovf);
        chk_t t;
        @(posedge wclk);
        #1;
        wrst     = r;
        winc     = i;
        wovf_clr = c;
        wq2_rptr = rp;
        if (chk) begin
            t.name      = nm;
            t.exp.wen   = e_wen;
            t.exp.waddr = e_addr;
            t.exp.wptr  = e_ptr;
            t.exp.full  = e_full;
            t.exp.afull = e_af & AF_ON;
            t.exp.level = e_lvl;
            t.exp.ovf   = e_ovf;
            sb.push_back(t);
        end
    endtask

    // Monitor: compare on the falling edge whenever an expectation is pending.
    initial begin : monitor
        chk_t t;
        obs_t a;
        forever begin
            @(negedge wclk);
            if (sb.size() > 0) begin
                t = sb.pop_front();
                a.wen   = wen;
                a.waddr = waddr;
                a.wptr  = wptr;
                a.full  = wfull;
                a.afull = wafull;
                a.level = wlevel;
                a.ovf   = wovf;
                n_chk++;
                if (a !== t.exp) begin
                    n_fail++;
                    $display("FAIL %s: got wen=%b waddr=%0d wptr=%b full=%b afull=%b level=%0d ovf=%b, want wen=%b waddr=%0d wptr=%b full=%b afull=%b level=%0d ovf=%b",
                             t.name, a.wen, a.waddr, a.wptr, a.full, a.afull, a.level, a.ovf,
                             t.exp.wen, t.exp.waddr, t.exp.wptr, t.exp.full, t.exp.afull,
                             t.exp.level, t.exp.ovf);
                end
            end
        end
    end

    initial begin : stim
        logic [3:0] rp;
        logic [3:0] lvl;

        // Reset held two cycles with a write requested.
        step("rst1", 1, 1, 0, 4'h0, 1, 0, 3'd0, 4'h0, 0, 0, 4'd0, 0);
        step("rst2", 1, 1, 0, 4'h0, 1, 0, 3'd0, 4'h0, 0, 0, 4'd0, 0);

        // Fill 8 entries with the reader idle.
        for (int i = 0; i < 8; i++) begin
            step($sformatf("fill%0d", i), 0, 1, 0, 4'h0, 1,
                 1, i[2:0], GRAY[i], 0, (i >= 6), i[3:0], 0);
        end

        // Overflow, sticky flag, clear, set-over-clear.
        step("ovf9",     0, 1, 0, 4'h0, 1, 0, 3'd0, 4'hC, 1, 1, 4'd8, 0);
        step("ovf_hold", 0, 0, 0, 4'h0, 1, 0, 3'd0, 4'hC, 1, 1, 4'd8, 1);
        step("ovf_clr",  0, 0, 1, 4'h0, 1, 0, 3'd0, 4'hC, 1, 1, 4'd8, 1);
        step("ovf_clrd", 0, 1, 1, 4'h0, 1, 0, 3'd0, 4'hC, 1, 1, 4'd8, 0);
        step("set_wins", 0, 0, 0, 4'h0, 1, 0, 3'd0, 4'hC, 1, 1, 4'd8, 1);
        step("ovf_clr2", 0, 0, 1, 4'h0, 1, 0, 3'd0, 4'hC, 1, 1, 4'd8, 1);

        // Reader frees one slot; a write in that same cycle is still refused.
        step("refuse",   0, 1, 0, 4'h1, 1, 0, 3'd0, 4'hC, 1, 1, 4'd8, 0);
        step("drain",    0, 0, 0, 4'h1, 1, 0, 3'd0, 4'hC, 0, 1, 4'd7, 1);
        step("ovf_clr3", 0, 0, 1, 4'h1, 1, 0, 3'd0, 4'hC, 0, 1, 4'd7, 1);
        step("refill",   0, 1, 0, 4'h1, 1, 1, 3'd0, 4'hC, 0, 1, 4'd7, 0);

        // Wrap: 16 writes with the read pointer trailing, full never asserts.
        step("rst_wrap", 1, 0, 0, 4'h0, 0, 0, 3'd0, 4'h0, 0, 0, 4'd0, 0);
        for (int j = 0; j < 16; j++) begin
            rp  = (j == 0) ? 4'h0 : GRAY[j-1];
            lvl = (j == 0) ? 4'd0 : (j == 1) ? 4'd1 : 4'd2;
            step($sformatf("wrap%0d", j), 0, 1, 0, rp, 1,
                 1, j[2:0], GRAY[j], 0, 0, lvl, 0);
        end
        step("wrap_end", 0, 0, 0, GRAY[15], 1, 0, 3'd0, 4'h0, 0, 0, 4'd2, 0);

        // Reset mid-fill beats a concurrent write.
        step("rst_mid", 1, 0, 0, 4'h0, 0, 0, 3'd0, 4'h0, 0, 0, 4'd0, 0);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("mfill%0d", i), 0, 1, 0, 4'h0, 1,
                 1, i[2:0], GRAY[i], 0, 0, i[3:0], 0);
        end
        step("mrst_in",  1, 1, 0, 4'h0, 1, 0, 3'd5, 4'h7, 0, 0, 4'd5, 0);
        step("mrst_out", 0, 0, 0, 4'h0, 1, 0, 3'd0, 4'h0, 0, 0, 4'd0, 0);

        repeat (3) @(posedge wclk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expectations pending, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 Parameter ADDR_SIZE, default 3, memory address width; depth = 2**ADDR_SIZE.
REQ-002 Parameter AFULL_THRESH, default 6, fill level at or above which the FIFO is almost full; range 1..2**ADDR_SIZE.
REQ-003 wclk  input  1  write clock; every register updates on its rising edge.
REQ-004 wrst  input  1  reset, synchronous, active-high.
REQ-005 winc  input  1  write request from the producer.
REQ-006 wq2_rptr  input  ADDR_SIZE+1  read pointer, Gray code, already synchronized into wclk.
REQ-007 wovf_clr  input  1  clears the sticky overflow flag.
REQ-008 wptr  output  ADDR_SIZE+1  write pointer, Gray code, registered; goes to the read-side synchronizer.
REQ-009 waddr  output  ADDR_SIZE  memory write address.
REQ-010 wen  output  1  memory write strobe.
REQ-011 wfull  output  1  full flag, registered.
REQ-012 wafull  output  1  almost-full flag, registered.
REQ-013 wlevel  output  ADDR_SIZE+1  fill level, registered, range 0..2**ADDR_SIZE.
REQ-014 wovf  output  1  sticky overflow flag, registered.

Function
REQ-015 The internal binary pointer wbin SHALL be ADDR_SIZE+1 bits wide; waddr = wbin[ADDR_SIZE-1:0], combinational.
REQ-016 wen = winc & ~wfull, combinational; a write is accepted in any cycle where wen = 1.
REQ-017 wbin_next = wbin + wen, modulo 2**(ADDR_SIZE+1); wrap-around SHALL be silent.
REQ-018 wptr SHALL load wbin_next ^ (wbin_next >> 1) on every clock edge.
REQ-019 wfull SHALL load (gray(wbin_next) == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]}); for ADDR_SIZE = 1, both bits are inverted.
REQ-020 wlevel SHALL load wbin_next - gray2bin(wq2_rptr), computed modulo 2**(ADDR_SIZE+1).
REQ-021 Flag latency: wfull and wlevel reflect an accepted write in the cycle after acceptance.
REQ-022 Flag latency: wfull and wlevel reflect a change on wq2_rptr in the cycle after that change; deassertion of wfull is pessimistic by the synchronizer delay.
REQ-023 winc = 1 while wfull = 1 SHALL set wovf; wbin, wptr and memory contents SHALL stay unchanged.
REQ-024 wovf SHALL stay set until wovf_clr = 1 or wrst = 1.
REQ-025 If wovf_clr and a new overflow occur in the same cycle, set SHALL win.
REQ-026 If winc arrives in the same cycle that wq2_rptr frees space while wfull = 1, the write SHALL be refused; wfull uses only the registered value.

Reset
REQ-027 While wrst = 1 at a wclk edge, wbin = 0, wptr = 0, wfull = 0, wafull = 0, wlevel = 0, wovf = 0.
REQ-028 wen SHALL be 0 during reset; a write requested in a reset cycle is discarded.
REQ-029 Reset mid-operation SHALL take priority over winc and wovf_clr.
REQ-030 The read side SHALL be reset in the same window as this block; this block does not detect mismatched resets.

Configuration
REQ-031 Macro FIFO_WR_AFULL_EN defined: wafull loads (wlevel_next >= AFULL_THRESH), with wlevel_next as defined in REQ-020.
REQ-032 Macro FIFO_WR_AFULL_EN undefined: the wafull port remains and is tied to 0, and no threshold comparator is built.

Structure
REQ-033 Shared package fifo_pkg SHALL hold the default ADDR_SIZE and the Gray-to-binary and binary-to-Gray helper functions; the read-side block uses the same package.
REQ-034 Sub-module fifo_gray2bin (parameterized width, combinational) SHALL convert wq2_rptr to binary.
REQ-035 No other sub-modules; the memory and the pointer synchronizers are outside this block.

Verification (ADDR_SIZE = 3, AFULL_THRESH = 6)
REQ-036 Reset: hold wrst for 2 cycles with winc = 1 -> all outputs 0, wen = 0.
REQ-037 Fill: wq2_rptr = 0, 8 consecutive writes -> after the 8th write, wptr = 4'b1100, wlevel = 8, wfull = 1, wafull = 1; wafull first rises the cycle after the 6th write.
REQ-038 Overflow: 9th winc while full -> wen = 0, wptr stays 4'b1100, wovf = 1; pulse wovf_clr -> wovf = 0 next cycle.
REQ-039 Drain: set wq2_rptr = 4'b0001 -> next cycle wfull = 0 and wlevel = 7; wafull stays 1.
REQ-040 Wrap: run 16 writes with wq2_rptr tracking at lag 2 -> wptr returns to 4'b0000, wfull never asserts, wlevel = 2 at steady state.
REQ-041 Reset mid-fill: after 5 writes, assert wrst together with winc -> next cycle wptr = 0, wlevel = 0, wen = 0.
